// File: rtl/hpi_txn_arbiter.sv
// hpi_txn_arbiter
// Round-robin arbiter and transaction sequencer for the CY7C67200 HPI bridge.
// Two requesters share one bridge; each accepted request runs a timed
// SETUP / STROBE / HOLD sequence on the active-low bridge strobes and ends
// with a one-cycle DONE state that returns a response to the owning port.
// All bridge-facing strobes, address/data and response outputs are registered.

module hpi_txn_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int RD_LAT     = 2
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_addr,
    input  logic        req0_we,
    input  logic [15:0] req0_wdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_addr,
    input  logic        req1_we,
    input  logic [15:0] req1_wdata,

    output logic        rsp0_valid,
    output logic [15:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_rdata,

    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic        hpi_cs_n,

    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // A read must stay in HOLD until the delayed bridge data has been captured.
    localparam int RD_HOLD_CYC = (RD_LAT > HOLD_CYC) ? RD_LAT : HOLD_CYC;

    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] WR_HOLD_LAST = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RD_HOLD_LAST = 4'(RD_HOLD_CYC - 1);
    localparam logic [3:0] CAPTURE_PH   = 4'(RD_LAT - 1);

    state_t      state_r;
    logic [3:0]  phase_r;
    logic        we_r;
    logic        owner_r;
    logic        last_served_r;
    logic [15:0] rd_data_r;

    logic        cs_n_r;
    logic        r_n_r;
    logic        w_n_r;
    logic [1:0]  addr_r;
    logic [15:0] dout_r;
    logic        busy_r;
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic [15:0] rsp0_rdata_r;
    logic [15:0] rsp1_rdata_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        idle_s;
    logic        accept_s;
    logic [3:0]  hold_last_s;
    logic        capture_s;
    logic [15:0] rd_next_s;

    // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && (!req1_valid || last_served_r)) begin
            grant0_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
        end
        if (req1_valid && (!req0_valid || !last_served_r)) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
    end

    // HOLD length and read-data capture point depend on the direction of the transfer.
    always_comb begin
        hold_last_s = WR_HOLD_LAST;
        capture_s   = 1'b0;
        rd_next_s   = rd_data_r;
        if (we_r) begin
            hold_last_s = WR_HOLD_LAST;
            capture_s   = 1'b0;
        end else begin
            hold_last_s = RD_HOLD_LAST;
            capture_s   = (state_r == HOLD) && (phase_r == CAPTURE_PH);
        end
        if (capture_s) begin
            rd_next_s = hpi_data_in;
        end else begin
            rd_next_s = rd_data_r;
        end
    end

    assign idle_s     = (state_r == IDLE);
    assign req0_ready = idle_s && grant0_s;
    assign req1_ready = idle_s && grant1_s;
    assign accept_s   = req0_ready || req1_ready;

    // Transaction sequencer: state, phase counter and all registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r       <= IDLE;
            phase_r       <= 4'd0;
            we_r          <= 1'b0;
            owner_r       <= 1'b0;
            last_served_r <= 1'b1;
            rd_data_r     <= 16'd0;
            cs_n_r        <= 1'b1;
            r_n_r         <= 1'b1;
            w_n_r         <= 1'b1;
            addr_r        <= 2'd0;
            dout_r        <= 16'd0;
            busy_r        <= 1'b0;
            rsp0_valid_r  <= 1'b0;
            rsp1_valid_r  <= 1'b0;
            rsp0_rdata_r  <= 16'd0;
            rsp1_rdata_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= SETUP;
                        phase_r <= 4'd0;
                        cs_n_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        owner_r <= req1_ready;
                        if (req1_ready) begin
                            addr_r <= req1_addr;
                            dout_r <= req1_wdata;
                            we_r   <= req1_we;
                        end else begin
                            addr_r <= req0_addr;
                            dout_r <= req0_wdata;
                            we_r   <= req0_we;
                        end
                    end
                end
                SETUP: begin
                    if (phase_r == SETUP_LAST) begin
                        state_r <= STROBE;
                        phase_r <= 4'd0;
                        r_n_r   <= we_r;
                        w_n_r   <= !we_r;
                    end else begin
                        phase_r <= phase_r + 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_r == STROBE_LAST) begin
                        state_r <= HOLD;
                        phase_r <= 4'd0;
                        r_n_r   <= 1'b1;
                        w_n_r   <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 4'd1;
                    end
                end
                HOLD: begin
                    rd_data_r <= rd_next_s;
                    if (phase_r == hold_last_s) begin
                        state_r <= DONE;
                        phase_r <= 4'd0;
                        cs_n_r  <= 1'b1;
                        if (owner_r) begin
                            rsp1_valid_r <= 1'b1;
                            rsp1_rdata_r <= we_r ? 16'd0 : rd_next_s;
                        end else begin
                            rsp0_valid_r <= 1'b1;
                            rsp0_rdata_r <= we_r ? 16'd0 : rd_next_s;
                        end
                    end else begin
                        phase_r <= phase_r + 4'd1;
                    end
                end
                DONE: begin
                    state_r       <= IDLE;
                    phase_r       <= 4'd0;
                    rsp0_valid_r  <= 1'b0;
                    rsp1_valid_r  <= 1'b0;
                    last_served_r <= owner_r;
                    busy_r        <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    phase_r      <= 4'd0;
                    cs_n_r       <= 1'b1;
                    r_n_r        <= 1'b1;
                    w_n_r        <= 1'b1;
                    busy_r       <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign hpi_cs_n     = cs_n_r;
    assign hpi_r_n      = r_n_r;
    assign hpi_w_n      = w_n_r;
    assign hpi_address  = addr_r;
    assign hpi_data_out = dout_r;
    assign busy         = busy_r;
    assign rsp0_valid   = rsp0_valid_r;
    assign rsp1_valid   = rsp1_valid_r;
    assign rsp0_rdata   = rsp0_rdata_r;
    assign rsp1_rdata   = rsp1_rdata_r;

endmodule

// File: tb/tb_hpi_txn_arbiter.sv
// Scoreboard bench for hpi_txn_arbiter: one instance with default timing and one
// with stretched timing (SETUP=2, STROBE=3, HOLD=1, RD_LAT=3), each driving a
// small bridge model whose read data lags the read strobe by RD_LAT cycles.

module tb_hpi_txn_arbiter;

    localparam int S_C[2] = '{1, 2};
    localparam int T_C[2] = '{2, 3};
    localparam int H_C[2] = '{1, 1};
    localparam int L_C[2] = '{2, 3};

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    logic        Clk;
    logic        Reset;

    logic        rv[2][2];
    logic        rr[2][2];
    logic [1:0]  raddr[2][2];
    logic        rwe[2][2];
    logic [15:0] rwd[2][2];
    logic        sv[2][2];
    logic [15:0] srd[2][2];
    logic [1:0]  haddr[2];
    logic [15:0] hdo[2];
    logic [15:0] hdi[2];
    logic        hr[2];
    logic        hw[2];
    logic        hcs[2];
    logic        bsy[2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t sb0[$];
    txn_t sb1[$];
    int   acc_hist[$];
    int   grants[$];

    logic        act[2];
    int          acc_c[2];
    logic [63:0] csm[2];
    logic [63:0] rm[2];
    logic [63:0] wm[2];
    int          bad[2];
    int          last_srv[2];
    int          gap_run[2];
    int          min_gap[2];
    logic        seen_low[2];

    hpi_txn_arbiter u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(rv[0][0]), .req0_ready(rr[0][0]), .req0_addr(raddr[0][0]),
        .req0_we(rwe[0][0]), .req0_wdata(rwd[0][0]),
        .req1_valid(rv[0][1]), .req1_ready(rr[0][1]), .req1_addr(raddr[0][1]),
        .req1_we(rwe[0][1]), .req1_wdata(rwd[0][1]),
        .rsp0_valid(sv[0][0]), .rsp0_rdata(srd[0][0]),
        .rsp1_valid(sv[0][1]), .rsp1_rdata(srd[0][1]),
        .hpi_address(haddr[0]), .hpi_data_out(hdo[0]), .hpi_data_in(hdi[0]),
        .hpi_r_n(hr[0]), .hpi_w_n(hw[0]), .hpi_cs_n(hcs[0]), .busy(bsy[0])
    );

    hpi_txn_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .RD_LAT(3)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(rv[1][0]), .req0_ready(rr[1][0]), .req0_addr(raddr[1][0]),
        .req0_we(rwe[1][0]), .req0_wdata(rwd[1][0]),
        .req1_valid(rv[1][1]), .req1_ready(rr[1][1]), .req1_addr(raddr[1][1]),
        .req1_we(rwe[1][1]), .req1_wdata(rwd[1][1]),
        .rsp0_valid(sv[1][0]), .rsp0_rdata(srd[1][0]),
        .rsp1_valid(sv[1][1]), .rsp1_rdata(srd[1][1]),
        .hpi_address(haddr[1]), .hpi_data_out(hdo[1]), .hpi_data_in(hdi[1]),
        .hpi_r_n(hr[1]), .hpi_w_n(hw[1]), .hpi_cs_n(hcs[1]), .busy(bsy[1])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle counter used for latency and window bookkeeping.
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom(input int d, input logic [1:0] a);
        logic [15:0] v;
        case (a)
            2'd0:    v = 16'h0F0F;
            2'd1:    v = 16'h1234;
            2'd2:    v = 16'hCAFE;
            default: v = 16'h5A5A;
        endcase
        if (d == 1) v = v ^ 16'hFFFF;
        return v;
    endfunction

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m;
        m = 64'd0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    // Bridge models: read strobe registered RD_LAT-1 times, then a data-in register.
    logic p0_a = 1'b1;
    logic p1_a = 1'b1;
    logic p1_b = 1'b1;
    always @(posedge Clk) begin
        p0_a   <= hr[0];
        hdi[0] <= (!p0_a) ? rom(0, haddr[0]) : 16'hDEAD;
        p1_a   <= hr[1];
        p1_b   <= p1_a;
        hdi[1] <= (!p1_b) ? rom(1, haddr[1]) : 16'hDEAD;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic mon_step(input int d);
        txn_t t;
        int   n;
        int   lat;
        int   p;
        int   ep;
        if (Reset) begin
            act[d]      = 1'b0;
            last_srv[d] = 1;
            seen_low[d] = 1'b0;
            gap_run[d]  = 0;
            if (d == 0) sb0.delete(); else sb1.delete();
            return;
        end
        n = cyc - acc_c[d];
        check_eq("busy", bsy[d], (act[d] && n >= 1));
        if (!hcs[d]) begin
            if (seen_low[d] && gap_run[d] > 0 && gap_run[d] < min_gap[d]) min_gap[d] = gap_run[d];
            seen_low[d] = 1'b1;
            gap_run[d]  = 0;
        end else begin
            gap_run[d]++;
        end
        if (act[d]) begin
            if (d == 0) t = sb0[0]; else t = sb1[0];
            if (n >= 1 && n < 64) begin
                csm[d][n] = !hcs[d];
                rm[d][n]  = !hr[d];
                wm[d][n]  = !hw[d];
                if (haddr[d] !== t.addr || hdo[d] !== t.wdata) bad[d]++;
            end
        end else begin
            check_eq("idle_strobes", {hcs[d], hr[d], hw[d]}, 3'b111);
        end
        if (sv[d][0] || sv[d][1]) begin
            check_eq("rsp_one_hot", $countones({sv[d][1], sv[d][0]}), 1);
            if (q_size(d) == 0) begin
                check_eq("rsp_unexpected", {sv[d][1], sv[d][0]}, 2'b00);
            end else begin
                if (d == 0) t = sb0.pop_front(); else t = sb1.pop_front();
                p   = sv[d][1] ? 1 : 0;
                lat = S_C[d] + T_C[d] + (t.we ? H_C[d] : imax(H_C[d], L_C[d])) + 1;
                check_eq("rsp_port", p, t.port);
                check_eq("rsp_rdata", srd[d][p], t.we ? 16'h0000 : rom(d, t.addr));
                check_eq("rsp_latency", n, lat);
                check_eq("cs_window", csm[d], range_mask(1, lat - 1));
                check_eq("r_window", rm[d], t.we ? 64'd0 : range_mask(S_C[d] + 1, S_C[d] + T_C[d]));
                check_eq("w_window", wm[d], t.we ? range_mask(S_C[d] + 1, S_C[d] + T_C[d]) : 64'd0);
                check_eq("addr_data_stable", bad[d], 0);
                last_srv[d] = p;
                act[d]      = 1'b0;
            end
        end
        if (rr[d][0] || rr[d][1]) begin
            check_eq("ready_one_hot", $countones({rr[d][1], rr[d][0]}), 1);
            check_eq("accept_when_idle", act[d], 1'b0);
            p  = rr[d][1] ? 1 : 0;
            ep = (rv[d][0] && rv[d][1]) ? ((last_srv[d] == 0) ? 1 : 0) : (rv[d][0] ? 0 : 1);
            check_eq("grant", p, ep);
            check_eq("ready_needs_valid", rv[d][p], 1'b1);
            t.port  = p;
            t.we    = rwe[d][p];
            t.addr  = raddr[d][p];
            t.wdata = rwd[d][p];
            if (d == 0) sb0.push_back(t); else sb1.push_back(t);
            act[d]   = 1'b1;
            acc_c[d] = cyc;
            csm[d]   = 64'd0;
            rm[d]    = 64'd0;
            wm[d]    = 64'd0;
            bad[d]   = 0;
            if (d == 0) begin
                acc_hist.push_back(cyc);
                grants.push_back(p);
            end
        end
    endtask

    // Monitor: scoreboard, strobe windows, grant order and busy, sampled mid-cycle.
    initial begin
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; acc_c[d] = 0; last_srv[d] = 1; gap_run[d] = 0;
            min_gap[d] = 1000; seen_low[d] = 1'b0; bad[d] = 0;
            csm[d] = 64'd0; rm[d] = 64'd0; wm[d] = 64'd0;
        end
        forever begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic do_req(input int d, input int p, input logic we, input logic [1:0] a, input logic [15:0] w);
        bit got;
        got = 1'b0;
        rwe[d][p]   = we;
        raddr[d][p] = a;
        rwd[d][p]   = w;
        rv[d][p]    = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (rr[d][p]) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("ready_seen", got, 1'b1);
        @(posedge Clk);
        #1;
        rv[d][p] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit done_b;
        done_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge Clk);
            #1;
            if (!act[d] && q_size(d) == 0) begin
                done_b = 1'b1;
                break;
            end
        end
        check_eq("idle_reached", done_b, 1'b1);
    endtask

    initial begin
        Reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                rv[d][p] = 1'b0; rwe[d][p] = 1'b0; raddr[d][p] = 2'd0; rwd[d][p] = 16'd0;
            end
        end
        repeat (2) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_strobes", {hcs[d], hr[d], hw[d]}, 3'b111);
            check_eq("rst_addr", haddr[d], 2'd0);
            check_eq("rst_dout", hdo[d], 16'd0);
            check_eq("rst_rsp_valid", {sv[d][1], sv[d][0]}, 2'b00);
            check_eq("rst_rdata", {srd[d][1], srd[d][0]}, 32'd0);
            check_eq("rst_busy", bsy[d], 1'b0);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Single write and single read on the default-timing instance.
        do_req(0, 0, 1'b1, 2'd2, 16'hBEEF);
        wait_idle(0);
        do_req(0, 1, 1'b0, 2'd1, 16'h0000);
        wait_idle(0);

        // Both ports contending: grants must alternate starting with port 0.
        grants.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 0, 1'b1, 2'(i), 16'hA000 + 16'(i));
            end
            begin
                for (int i = 0; i < 4; i++) do_req(0, 1, 1'b1, 2'(3 - i), 16'hB000 + 16'(i));
            end
        join
        wait_idle(0);
        check_eq("grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) check_eq("grant_alternate", grants[i], i % 2);

        // Back-to-back single-port spacing.
        acc_hist.delete();
        do_req(0, 0, 1'b1, 2'd3, 16'h1357);
        do_req(0, 0, 1'b1, 2'd0, 16'h2468);
        wait_idle(0);
        check_eq("b2b_write_spacing", acc_hist[1] - acc_hist[0], 6);
        acc_hist.delete();
        do_req(0, 0, 1'b0, 2'd2, 16'h0001);
        do_req(0, 0, 1'b0, 2'd3, 16'h0002);
        wait_idle(0);
        check_eq("b2b_read_spacing", acc_hist[1] - acc_hist[0], 7);

        // Stretched-timing instance: read (long HOLD) then write.
        do_req(1, 1, 1'b0, 2'd2, 16'h7777);
        wait_idle(1);
        do_req(1, 0, 1'b1, 2'd1, 16'h8888);
        wait_idle(1);
        do_req(1, 0, 1'b0, 2'd3, 16'h9999);
        wait_idle(1);

        // Reset during the write strobe.
        do_req(0, 0, 1'b1, 2'd1, 16'h1111);
        @(posedge Clk);
        #3;
        check_eq("strobe_before_rst", {hcs[0], hw[0]}, 2'b00);
        Reset = 1'b1;
        #1;
        check_eq("rst_async_w_cs", {hcs[0], hw[0], hr[0]}, 3'b111);
        check_eq("rst_async_busy", bsy[0], 1'b0);
        check_eq("rst_async_rsp", {sv[0][1], sv[0][0]}, 2'b00);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        do_req(0, 0, 1'b1, 2'd0, 16'h2222);
        wait_idle(0);

        check_eq("cs_gap0", (min_gap[0] >= 2), 1'b1);
        check_eq("cs_gap1", (min_gap[1] >= 2), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
